sram_ins_fetch_queue: RTL

Upstream neighbour of the note execute stage in the music CPU. It walks program memory in the external async SRAM from address 0 and classifies each 16-bit word. BPM words update a tempo register and are not forwarded; note words are queued together with the tempo in force when they were fetched. The execute stage pops notes through a valid/ready handshake and so never touches SRAM timing.

---
 rtl/sram_ins_fetch_queue_pkg.sv | 44 ++++
 rtl/sram_ins_fetch_queue_if.sv | 26 ++
 rtl/sram_ins_fetch_queue_ins_fifo.sv | 66 ++++++
 rtl/sram_ins_fetch_queue.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sram_ins_fetch_queue_pkg.sv
// Shared types and constants for the SRAM instruction fetch queue:
// opcode fields, FSM states, queue-entry layout and word classification.
package sram_ins_fetch_queue_pkg;

  localparam int          NOTE_BIT        = 15;
  localparam logic [3:0]  OP_END          = 4'b0000;
  localparam logic [3:0]  OP_BPM          = 4'b0001;
  localparam logic [11:0] DEFAULT_BPM_VAL = 12'd96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    W_NOTE,
    W_END,
    W_BPM,
    W_BAD
  } word_kind_t;

  typedef struct packed {
    logic [15:0] ins;
    logic [11:0] bpm;
  } ins_entry_t;

  function automatic word_kind_t classify(input logic [15:0] word);
    word_kind_t kind;
    if (word[NOTE_BIT])              kind = W_NOTE;
    else if (word[15:12] == OP_END)  kind = W_END;
    else if (word[15:12] == OP_BPM)  kind = W_BPM;
    else                             kind = W_BAD;
    return kind;
  endfunction

  // A zero tempo would stall the execute stage's beat timer forever.
  function automatic logic [11:0] clamp_bpm(input logic [11:0] value);
    return (value == 12'd0) ? 12'd1 : value;
  endfunction

endpackage

// File: rtl/sram_ins_fetch_queue_if.sv
// Bus bundle of the fetch queue: SRAM read port, note pop handshake and status.
// master = the fetch queue itself, slave = SRAM plus execute stage side.
interface sram_ins_fetch_queue_if #(
  parameter int ADDR_W = 18
);
  logic              START;
  logic [ADDR_W-1:0] SRAM_A;
  logic              SRAM_OE;
  logic [15:0]       SRAM_D;
  logic              INS_VALID;
  logic              INS_READY;
  logic [15:0]       INS_DATA;
  logic [11:0]       INS_BPM;
  logic              DONE;
  logic              BAD_INS;

  modport master (
    input  START, SRAM_D, INS_READY,
    output SRAM_A, SRAM_OE, INS_VALID, INS_DATA, INS_BPM, DONE, BAD_INS
  );

  modport slave (
    output START, SRAM_D, INS_READY,
    input  SRAM_A, SRAM_OE, INS_VALID, INS_DATA, INS_BPM, DONE, BAD_INS
  );
endinterface

// File: rtl/sram_ins_fetch_queue_ins_fifo.sv
// Synchronous DEPTH-entry FIFO of {note, tempo} entries with flush, count and
// a combinational head. Storage is not reset; only pointers and count are.
module sram_ins_fetch_queue_ins_fifo
  import sram_ins_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  ins_entry_t               push_entry,
  input  logic                     pop,
  output ins_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ins_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH)) && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sram_ins_fetch_queue.sv
// Fetches music program words from async SRAM, tracks tempo and queues notes.
// Optional macro SRAM_INS_FETCH_HALT_ON_BAD_EN: a bad opcode halts like END.
module sram_ins_fetch_queue
  import sram_ins_fetch_queue_pkg::*;
#(
  parameter int          ADDR_W      = 18,
  parameter int          DEPTH       = 4,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [11:0] DEFAULT_BPM = DEFAULT_BPM_VAL
) (
  input  logic                  CLK,
  input  logic                  RST,
  sram_ins_fetch_queue_if.master bus
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic              sram_oe_q, sram_oe_d;
  logic [11:0]       tempo_q, tempo_d;
  logic              bad_q, bad_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  ins_entry_t        push_entry, head;
  logic [CNT_W-1:0]  fifo_count;
  logic              ins_valid;

  sram_ins_fetch_queue_ins_fifo #(
    .DEPTH (DEPTH)
  ) u_ins_fifo (
    .clk        (CLK),
    .rst        (RST),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (fifo_count)
  );

  assign ins_valid = (fifo_count != '0);
  assign fifo_pop  = ins_valid && bus.INS_READY;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tempo_d    = tempo_q;
    bad_d      = bad_q;
    wait_cnt_d = wait_cnt_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    push_entry = '{ins: bus.SRAM_D, bpm: tempo_q};

    case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_ADDR;
      end
      // Only launch a read when the eventual push is guaranteed a free slot.
      S_ADDR: begin
        if (fifo_count < CNT_W'(DEPTH)) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1)) state_d = S_CAPTURE;
        else                                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
      end
      S_CAPTURE: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_ADDR;
        case (classify(bus.SRAM_D))
          W_NOTE:  fifo_push = 1'b1;
          W_BPM:   tempo_d   = clamp_bpm(bus.SRAM_D[11:0]);
          W_END:   state_d   = S_HALT;
          default: begin
            bad_d = 1'b1;
`ifdef SRAM_INS_FETCH_HALT_ON_BAD_EN
            state_d = S_HALT;
`else
            state_d = S_ADDR;
`endif
          end
        endcase
      end
      S_HALT: begin
        if (bus.START) begin
          fifo_flush = 1'b1;
          pc_d       = '0;
          tempo_d    = DEFAULT_BPM;
          bad_d      = 1'b0;
          state_d    = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address is latched on entry to ADDR and held through WAIT/CAPTURE.
    sram_a_d  = (state_d == S_ADDR) ? pc_d : sram_a_q;
    sram_oe_d = !(state_d inside {S_ADDR, S_WAIT, S_CAPTURE});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      sram_a_q   <= '0;
      sram_oe_q  <= 1'b1;
      tempo_q    <= DEFAULT_BPM;
      bad_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sram_a_q   <= sram_a_d;
      sram_oe_q  <= sram_oe_d;
      tempo_q    <= tempo_d;
      bad_q      <= bad_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.SRAM_A    = sram_a_q;
  assign bus.SRAM_OE   = sram_oe_q;
  assign bus.INS_VALID = ins_valid;
  assign bus.INS_DATA  = ins_valid ? head.ins : 16'h0000;
  assign bus.INS_BPM   = ins_valid ? head.bpm : DEFAULT_BPM;
  assign bus.DONE      = (state_q == S_HALT) && !ins_valid;
  assign bus.BAD_INS   = bad_q;

endmodule
